// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_e;

  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic                 neg,
                                                   input logic [DIV_WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring shift-subtract step: trial subtract plus restore mux.
module alu_div_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvs always holds, so the shifted value is below 2*dvs and the
  // WIDTH+1-bit difference keeps a valid sign bit.
  assign shifted  = {rem, dvd_bit};
  assign trial    = shifted - {1'b0, dvs};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_div32.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Define ALU_DIV_SIGNED_EN to honour is_signed (two's-complement operands).
module alu_div32
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [0:WIDTH-1] dividend,
  input  logic [0:WIDTH-1] divisor,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] quotient,
  output logic [0:WIDTH-1] remainder,
  output logic             div_by_zero
);

  state_e           state, next_state;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, q_raw, q_res, r_res;
  logic             step_q;
  logic             div_zero, last_iter;

  assign div_zero  = (divisor == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .dvs     (dvs),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  assign q_raw = {dvd[WIDTH-2:0], step_q};

`ifdef ALU_DIV_SIGNED_EN
  logic a_neg, b_neg, q_neg, r_neg;

  // Port bit 0 is the MSB, i.e. the sign bit
  assign a_neg = is_signed & dividend[0];
  assign b_neg = is_signed & divisor[0];
  assign a_mag = neg_if(a_neg, dividend);
  assign b_mag = neg_if(b_neg, divisor);
  assign q_res = neg_if(q_neg, q_raw);
  assign r_res = neg_if(r_neg, step_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_res = q_raw;
  assign r_res = step_rem;
`endif

  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = div_zero ? FINISH : ITER;
      ITER:    if (last_iter) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem         <= '0;
            cnt         <= '0;
            dvd         <= a_mag;
            dvs         <= b_mag;
            div_by_zero <= div_zero;
            if (div_zero) begin
              quotient  <= DIV_ZERO_Q;
              remainder <= dividend;
            end
          end
        end
        ITER: begin
          rem <= step_rem;
          dvd <= q_raw;
          cnt <= cnt + CNT_W'(1);
          // Results land on the edge entering FINISH so they are valid with done
          if (last_iter) begin
            quotient  <= q_res;
            remainder <= r_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule

// File: doc/alu_div32.md
# alu_div32

Multi-cycle iterative integer divider for the execute-stage ALU; the inverse companion of the 32-bit carry-lookahead adder. It accepts one dividend/divisor pair on a start pulse and retires one quotient bit per cycle by restoring shift-subtract. It delivers quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.
- `clk` input 1 — single clock, all state on rising edge.
- `rst_n` input 1 — asynchronous active-low reset.
- `start` input 1 — request; sampled only in IDLE.
- `is_signed` input 1 — 1 = two's-complement operands, 0 = unsigned.
- `dividend` input [0:WIDTH-1] — bit 0 is MSB.
- `divisor` input [0:WIDTH-1] — bit 0 is MSB.
- `busy` output 1 — high from the cycle after accepted start until done cycle inclusive.
- `done` output 1 — one-cycle pulse; results valid in this cycle.
- `quotient` output [0:WIDTH-1] — held from done until the next accepted start.
- `remainder` output [0:WIDTH-1] — held likewise.
- `div_by_zero` output 1 — valid with done; held likewise.

## Operation
- States: IDLE, ITER, FINISH.
- IDLE: on `start`=1, latch operand magnitudes, result signs (q_neg = sign(a) XOR sign(b), r_neg = sign(a), signed mode only), clear partial remainder and counter.
  - Divisor nonzero: go to ITER.
  - Divisor zero: set the zero flag and go directly to FINISH.
- ITER: each cycle:
  - shift {rem, dvd} left by 1;
  - compute 33-bit trial = rem − |divisor|;
  - if trial is non-negative, rem = trial and shift in quotient bit 1; otherwise rem is unchanged and quotient bit is 0;
  - counter++; after the 32nd iteration go to FINISH.
- FINISH: drive results.
  - Negate quotient if q_neg; negate remainder if r_neg.
  - Assert `done` and drive `div_by_zero`.
  - Next state is IDLE.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend unchanged, `div_by_zero`=1, in both modes.
- Signed overflow: 0x80000000 / 0xFFFFFFFF produces quotient 0x80000000 and remainder 0 with no special case, since the magnitude 2^31 fits unsigned.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- `start` while busy: ignored, and operands are not re-latched.
- `rst_n` low at any time, including mid-iteration: state returns to IDLE and the current operation is abandoned.
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter=0.

## Timing
- Start accepted at edge E0.
- ITER occupies edges E1..E32, and FINISH is entered at E32.
- `done`=1 in the cycle following E32, i.e. 33 cycles after E0. Back-to-back start is allowed in the cycle after done.
- Divide by zero: `done`=1 in the cycle following E0, a 1-cycle latency.
- `busy`=1 in every cycle from after E0 through the done cycle; 0 otherwise.
- `done` is never high for more than one consecutive cycle.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `ALU_DIV_SIGNED_EN` defined: `is_signed` is honoured, and the magnitude/sign-fix logic is compiled in.
- Not defined: `is_signed` is ignored and all operands are treated as unsigned. Sign-fix logic is removed, and latency is unchanged.

## Structure
- Package `alu_div_pkg`:
  - state enum {IDLE, ITER, FINISH};
  - `DIV_WIDTH`=32, `DIV_CNT_W`=6;
  - divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, `alu_div_step`: combinational 33-bit trial subtract plus restore mux. Inputs are rem, next dividend bit and divisor magnitude; outputs are new rem and quotient bit. This keeps the subtract path swappable for a lookahead implementation.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, `div_by_zero`=0; `done` exactly 33 cycles after start; `busy` high 33 cycles.
- Signed (if `ALU_DIV_SIGNED_EN`) −100 / 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; 100 / −7 → quotient 0xFFFFFFF2, remainder 2.
- 0xDEADBEEF / 0 → quotient 0xFFFFFFFF, remainder 0xDEADBEEF, `div_by_zero`=1, `done` 1 cycle after start.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Second start pulsed with 5 / 1 at cycle 10 of a 100 / 7 operation → ignored; result is 14 / 2 and `done` pulses once.
- `rst_n` dropped at cycle 15 of an operation → `busy`, `done` and outputs 0 immediately; a fresh 9 / 3 afterwards → quotient 3, remainder 0.
